// File: rtl/rps_match_scoreboard.sv
// Match scoreboard for the stone-paper-scissors judge: counts round outcomes and declares the match winner.
// Counters update on the accept edge; result_ready drops outside PLAY and while new_match is pulsed.
module rps_match_scoreboard #(
    parameter int WIN_TARGET = 3,
    parameter int MAX_ROUNDS = 9,
    parameter int SCORE_W    = 4,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_match,
    input  logic               result_valid,
    input  logic [1:0]         result,
    output logic               result_ready,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [CNT_W-1:0]   round_cnt,
    output logic [CNT_W-1:0]   tie_cnt,
    output logic [CNT_W-1:0]   invalid_cnt,
    output logic               match_done,
    output logic [1:0]         match_winner,
    output logic [1:0]         sb_state
);

    localparam logic [SCORE_W-1:0] WIN_T = SCORE_W'(WIN_TARGET);
    localparam logic [CNT_W-1:0]   MAX_R = CNT_W'(MAX_ROUNDS);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state;
    logic               accept;
    logic               finish;
    logic [1:0]         winner_next;
    logic [SCORE_W-1:0] p1_next;
    logic [SCORE_W-1:0] p2_next;
    logic [CNT_W-1:0]   round_next;
    logic [CNT_W-1:0]   tie_next;
    logic [CNT_W-1:0]   invalid_next;

    function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign result_ready = (state == PLAY) && !new_match;
    assign accept       = result_valid && result_ready;
    assign sb_state     = state;

    // Post-update values drive both the counters and the end-of-match decision on the same edge.
    always_comb begin
        p1_next      = p1_score;
        p2_next      = p2_score;
        round_next   = round_cnt;
        tie_next     = tie_cnt;
        invalid_next = invalid_cnt;
        if (accept) begin
            case (result)
                2'b01: begin
                    p1_next    = sat_score(p1_score);
                    round_next = sat_cnt(round_cnt);
                end
                2'b10: begin
                    p2_next    = sat_score(p2_score);
                    round_next = sat_cnt(round_cnt);
                end
                2'b00: begin
                    tie_next   = sat_cnt(tie_cnt);
                    round_next = sat_cnt(round_cnt);
                end
                default: invalid_next = sat_cnt(invalid_cnt);
            endcase
        end
        finish = (p1_next == WIN_T) || (p2_next == WIN_T) || (round_next == MAX_R);
        if (p1_next > p2_next)
            winner_next = 2'b01;
        else if (p2_next > p1_next)
            winner_next = 2'b10;
        else
            winner_next = 2'b00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            p1_score     <= '0;
            p2_score     <= '0;
            round_cnt    <= '0;
            tie_cnt      <= '0;
            invalid_cnt  <= '0;
            match_done   <= 1'b0;
            match_winner <= 2'b00;
        end else if (new_match) begin
            state        <= PLAY;
            p1_score     <= '0;
            p2_score     <= '0;
            round_cnt    <= '0;
            tie_cnt      <= '0;
            invalid_cnt  <= '0;
            match_done   <= 1'b0;
            match_winner <= 2'b00;
        end else if (accept) begin
            p1_score    <= p1_next;
            p2_score    <= p2_next;
            round_cnt   <= round_next;
            tie_cnt     <= tie_next;
            invalid_cnt <= invalid_next;
            if (finish) begin
                state        <= DONE;
                match_done   <= 1'b1;
                match_winner <= winner_next;
            end
        end
    end

endmodule
